// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin mux arbiter.
// The master side holds the requesters. The slave side holds the arbiter.
interface mux_rr_arbiter_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned SEL_W = 4
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] sel;
    logic             valid;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  valid
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that sequences ownership of a shared N:1 mux.
// It uses a rotating priority pointer and bounds how long each grant may be held.
module mux_rr_arbiter #(
    parameter int unsigned N        = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_rr_arbiter_if.slave bus
);
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [N-1:0] ONE   = N'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;

    logic [N-1:0]     owner_mask;
    logic [N-1:0]     others;
    logic [N-1:0]     arb_req;
    logic [SEL_W-1:0] arb_ptr;
    logic             rel;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;

    // Release detection and the rotating-priority search.
    // After a release the search starts one past the owner, and the owner is skipped unless it is the only requester.
    always_comb begin
        logic [SEL_W-1:0] idx;
        owner_mask = ONE << sel_q;
        others     = bus.req & ~owner_mask;
        arb_ptr    = ptr_q;
        arb_req    = bus.req;
        rel        = 1'b0;
        if (state_q == GRANT) begin
            rel     = bus.done | ~|(bus.req & owner_mask)
                    | (hold_q == HOLD_W'(MAX_HOLD - 1));
            arb_ptr = sel_q + SEL_W'(1);
            arb_req = (others != '0) ? others : bus.req;
        end
        win_found = 1'b0;
        win_idx   = arb_ptr;
        for (int i = 0; i < int'(N); i++) begin
            idx = arb_ptr + SEL_W'(i);
            if (!win_found && arb_req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   if (rel && !win_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the bookkeeping registers.
    always_comb begin
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = ONE << win_idx;
                    sel_d   = win_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d  = sel_q + SEL_W'(1);
                    hold_d = '0;
                    if (win_found) begin
                        grant_d = ONE << win_idx;
                        sel_d   = win_idx;
                        valid_d = 1'b1;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter.
// It runs directed scenarios followed by random traffic, and compares against an ownership-level reference model.
module tb_mux_rr_arbiter;
    localparam int N        = 16;
    localparam int SEL_W    = 4;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model: who owns the mux, for how many cycles, and where the search starts next.
    int m_owner;
    int m_len;
    int m_ptr;
    int m_sel;

    mux_rr_arbiter_if #(.N(N), .SEL_W(SEL_W)) bus ();

    mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Advance the model by one clock, using the inputs present at the edge.
    function automatic void model_step(input logic r, input logic [N-1:0] rq, input logic d);
        logic [N-1:0] cand;
        int w;
        if (r) begin
            m_owner = -1; m_len = 0; m_ptr = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            w = first_from(rq, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_len = 1;
            end
        end else if (d || !rq[m_owner] || m_len == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % N;
            cand  = rq;
            cand[m_owner] = 1'b0;
            if (cand == '0) cand = rq;
            w = first_from(cand, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_len = 1;
            end else begin
                m_owner = -1; m_len = 0;
            end
        end else begin
            m_len++;
        end
    endfunction

    task automatic compare_model(input string tag);
        logic [31:0] eg;
        eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        chk({tag, "_grant"}, 32'(bus.grant), eg);
        chk({tag, "_sel"},   32'(bus.sel),   32'(m_sel));
        chk({tag, "_valid"}, 32'(bus.valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic tick(input string tag);
        logic         r;
        logic [N-1:0] rq;
        logic         d;
        r = rst; rq = bus.req; d = bus.done;
        @(posedge clk);
        model_step(r, rq, d);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.done = 1'b0;
        for (int k = 0; k < cycles; k++) tick("rst");
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_owner = -1; m_len = 0; m_ptr = 0; m_sel = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.done = 1'b0;
        #2;

        // Reset held while all requesters are asking.
        bus.req = 16'hFFFF;
        do_reset(2);
        tick("t1_first");
        chk("t1_first_grant0", 32'(bus.grant), 32'h1);

        // A lone requester is forced off and then re-granted without a gap.
        bus.req = '0;
        do_reset(1);
        bus.req = 16'h0020;
        tick("t2_start");
        chk("t2_sel5", 32'(bus.sel), 32'd5);
        for (int k = 0; k < 2 * MAX_HOLD + 2; k++) begin
            tick("t2_hold");
            chk("t2_no_gap", 32'(bus.valid), 32'd1);
        end

        // All requesting: sel rotates and each owner holds for exactly MAX_HOLD cycles.
        bus.req = '0;
        do_reset(1);
        bus.req = 16'hFFFF;
        for (int k = 1; k <= MAX_HOLD * (N + 1); k++) begin
            tick("t3");
            if (k % 4 == 1) chk("t3_rotation", 32'(bus.sel), 32'(((k - 1) / MAX_HOLD) % N));
        end

        // Done asserted in the fourth cycle of each grant: sel alternates 3 and 12.
        bus.req = '0;
        do_reset(1);
        bus.req = 16'h1008;
        for (int k = 1; k <= 16; k++) begin
            bus.done = (m_owner >= 0 && m_len == 4);
            tick("t4");
            chk("t4_alt", 32'(bus.sel), ((k - 1) / 4) % 2 == 0 ? 32'd3 : 32'd12);
        end
        bus.done = 1'b0;

        // The owner drops its request, so the arbiter goes idle and sel keeps its last value.
        bus.req = '0;
        do_reset(1);
        bus.req = 16'h0080;
        tick("t5_g");
        tick("t5_g");
        bus.req = '0;
        tick("t5_drop");
        chk("t5_sel_hold", 32'(bus.sel), 32'd7);
        chk("t5_idle", 32'(bus.valid), 32'd0);
        bus.req = 16'h0004;
        tick("t5_new");
        chk("t5_sel2", 32'(bus.sel), 32'd2);

        // Reset during a grant clears the pointer, so requester 0 wins next.
        bus.req = '0;
        do_reset(1);
        bus.req = 16'h0200;
        for (int k = 0; k < 5; k++) tick("t6_g");
        rst = 1'b1;
        bus.req = 16'h0201;
        tick("t6_rst");
        chk("t6_rst_grant", 32'(bus.grant), 32'h0);
        rst = 1'b0;
        tick("t6_after");
        chk("t6_first0", 32'(bus.grant), 32'h1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0: bus.req = N'($urandom);
                1: bus.req = N'($urandom) & N'($urandom);
                2: bus.req = N'(1) << $urandom_range(0, N - 1);
                default: if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            endcase
            bus.done = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
